imem_loader: RTL
================

# imem_loader

Instruction-memory loader and fetch port for the 16-entry, 32-bit pipeline core. It receives a program as a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It writes those words into a DEPTH-entry instruction memory, then signals `done` so the core can be released from reset. It also serves the fetch stage: a registered read port returns `mem[pc]` one cycle after `pc` is presented.

## Interface
- `WORD_W`, 32, instruction word width (fixed at 4 bytes).
- `DEPTH`, 16, number of instruction words.
- `ADDR_W`, 4, address width, log2(DEPTH).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load.
- `in_valid`  in  1  `in_byte` is valid.
- `in_byte`  in  8  program byte, word-LSB first.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `pc`  in  ADDR_W  fetch address.
- `instr`  out  WORD_W  registered `mem[pc]`.
- `busy`  out  1  a load is in progress (LOAD or CHECK state).
- `done`  out  1  the program is fully loaded.
- `words_loaded`  out  ADDR_W+1  count of words written in the current load.
- `err`  out  1  checksum mismatch; tied 0 unless checksum is compiled in.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), DONE.
- IDLE:
  - `in_ready`=0.
  - `start` moves to LOAD and clears `byte_idx`, `waddr`, `words_loaded`, checksum accumulator and `err`.
- LOAD:
  - `in_ready`=1.
  - A byte is accepted when `in_valid && in_ready`.
  - An accepted byte goes to assembly lane `byte_idx` (lane 0 = bits 7:0), and `byte_idx` increments mod 4.
  - On the 4th byte of a word, `{in_byte, lanes 2..0}` is written to `mem[waddr]`; `waddr` and `words_loaded` increment.
  - After word DEPTH-1 is written, go to CHECK if compiled in, else DONE.
- CHECK: `in_ready`=1; accepts exactly one checksum byte, then goes to DONE.
- DONE:
  - `done`=1, `in_ready`=0.
  - `start` re-enters LOAD with counters cleared; memory is overwritten word by word.
- `start` is ignored in LOAD and CHECK.
- Bytes offered while `in_ready`=0 are not consumed.
- Read port:
  - `instr <= mem[pc]` every cycle, in every state.
  - Same-edge read and write of one address returns the old data (read-before-write).
- Reset, including mid-load:
  - State returns to IDLE; all memory entries and the assembly register are zeroed.
  - `instr`=0, `in_ready`=0, `busy`=0, `done`=0, `words_loaded`=0, `err`=0.
  - A partial word is discarded.

## Timing
- `in_ready`, `busy` and `done` are decoded from the registered state; none depends combinationally on `in_valid`.
- `start` sampled at edge N: `in_ready`=1 from cycle N+1.
- The memory write, `waddr` increment and `words_loaded` increment all occur on the edge that accepts the word's 4th byte.
- Without the macro, `done`=1 in the cycle after the edge accepting byte 4·DEPTH. With the macro, it follows the checksum-byte edge.
- `instr` latency: 1 cycle from `pc`.
- The accepting throughput is one byte per cycle; arbitrary `in_valid` gaps are allowed.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit accumulator sums all accepted bytes mod 256, including the trailing checksum byte accepted in CHECK.
  - On leaving CHECK, `err`=1 if the sum ≠ 0x00, else `err`=0.
  - `err` holds until the next `start` or `rst`.
  - Memory contents are kept regardless of `err`.
- Macro undefined: no CHECK state or accumulator; LOAD goes directly to DONE; `err` is constant 0.

## Test plan
- Reset → `instr`=0x00000000 for all `pc`, `in_ready`=0, `done`=0, `words_loaded`=0.
- Load integrity: `start`, then bytes 0x00..0x3F streamed back-to-back →
  - `mem[0]`=0x03020100 and `mem[15]`=0x3F3E3D3C, read via `pc` with 1-cycle latency;
  - `words_loaded`=16, and `done`=1 one cycle after byte 0x3F (without the macro).
- Backpressure: the same stream with `in_valid` toggled 1,0,0,1,… → identical memory image; no byte lost or duplicated.
- Reset mid-load: assert `rst` after byte 10 → IDLE, `words_loaded`=0, `mem[0]`=0, `mem[1]`=0. A following full load succeeds.
- Read-during-write: `pc`=2 on the edge writing word 2 → `instr` shows the old value (0) that cycle and the new word the next cycle. `start` pulsed during LOAD has no effect.
- With `IMEM_LOADER_CHECKSUM_EN`: bytes 0x00..0x3F, then checksum 0x20 → `err`=0; checksum 0x21 → `err`=1. `done`=1 in both cases.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader that packs bytes little-endian into a DEPTH x WORD_W
// instruction memory, plus a registered fetch read port. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [WORD_W-1:0] instr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err
);

    localparam int                ASM_W     = WORD_W - 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 2'd3,
`endif
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign err      = err_q;
`else
    assign in_ready = (state_q == S_LOAD);
    assign err      = 1'b0;
`endif
    assign busy         = in_ready;
    assign done         = (state_q == S_DONE);
    assign words_loaded = words_q;
    assign instr        = instr_q;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        waddr_d    = waddr_q;
        words_d    = words_q;
        asm_d      = asm_q;
        mem_d      = mem_q;
        // Read sees the pre-write contents, giving read-before-write on a collision.
        instr_d    = mem_q[pc];
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    byte_idx_d = 2'd0;
                    waddr_d    = '0;
                    words_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
                    err_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + in_byte;
`endif
                    case (byte_idx_q)
                        2'd0:    asm_d[7:0]   = in_byte;
                        2'd1:    asm_d[15:8]  = in_byte;
                        2'd2:    asm_d[23:16] = in_byte;
                        default: begin
                            mem_d[waddr_q] = {in_byte, asm_q};
                            waddr_d        = waddr_q + ADDR_ONE;
                            words_d        = words_q + WORDS_ONE;
                            if (waddr_q == LAST_ADDR) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = S_CHECK;
`else
                                state_d = S_DONE;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (in_valid) begin
                    sum_d   = sum_q + in_byte;
                    err_d   = (sum_d != 8'd0);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            waddr_q    <= '0;
            words_q    <= '0;
            asm_q      <= '0;
            instr_q    <= '0;
            mem_q      <= '{default: '0};
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            waddr_q    <= waddr_d;
            words_q    <= words_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
            mem_q      <= mem_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule
